// File: rtl/adc_sample_uart_tx.sv
// ADC sample FIFO + UART 8N1 serializer: each 12-bit sample goes out as two marker-framed bytes (H then L).
// Latency: a sample written into an empty FIFO with the line idle is popped on the next edge; tx falls after that edge.
// Backpressure: none on input; a sample arriving while the FIFO is full (no pop) is dropped and counted. UART_PARITY_EN gives 8E1.
module adc_sample_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_data_valid,
    input  logic [11:0] I_data,
    output logic        O_uart_tx,
    output logic        O_busy,
    output logic        O_overflow,
    output logic [15:0] O_drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [TW-1:0]    TMR_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_nxt;

    logic [11:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [11:0]        rd_dat;
    logic               fifo_empty, fifo_full, push, pop;

    logic [TW-1:0] tmr;
    logic          bit_done;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [5:0]    hold;
    logic          byte_sel;
`ifdef UART_PARITY_EN
    logic          par;
`endif

    assign rd_dat     = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign pop        = (state == IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a full FIFO still takes the sample.
    assign push       = I_data_valid && (!fifo_full || pop);
    assign bit_done   = (tmr == TMR_LAST);

    always_ff @(posedge I_clk) begin
        if (push) mem[wr_ptr] <= I_data;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_overflow <= 1'b0;
            O_drop_cnt <= '0;
        end else if (I_data_valid && !push) begin
            O_overflow <= 1'b1;
            if (O_drop_cnt != 16'hFFFF) O_drop_cnt <= O_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!fifo_empty) state_nxt = START;
            START:  if (bit_done) state_nxt = DATA;
`ifdef UART_PARITY_EN
            DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
            PARITY: if (bit_done) state_nxt = STOP;
`else
            DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
            STOP:   if (bit_done) state_nxt = byte_sel ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        O_uart_tx = 1'b1;
        case (state)
            START:   O_uart_tx = 1'b0;
            DATA:    O_uart_tx = shift[0];
`ifdef UART_PARITY_EN
            PARITY:  O_uart_tx = par;
`endif
            default: O_uart_tx = 1'b1;
        endcase
    end

    assign O_busy = (state != IDLE) || !fifo_empty;

    // Bit timer restarts on every bit boundary, so back-to-back bytes need no gap cycle.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tmr      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            hold     <= '0;
            byte_sel <= 1'b0;
`ifdef UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tmr <= (state == IDLE || bit_done) ? '0 : tmr + 1'b1;
            if (pop) begin
                shift    <= {2'b10, rd_dat[11:6]};
                hold     <= rd_dat[5:0];
                byte_sel <= 1'b0;
`ifdef UART_PARITY_EN
                par      <= ^{2'b10, rd_dat[11:6]};
`endif
            end
            if (state == START && bit_done) bit_idx <= '0;
            if (state == DATA && bit_done) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == STOP && bit_done && !byte_sel) begin
                shift    <= {2'b00, hold};
                byte_sel <= 1'b1;
`ifdef UART_PARITY_EN
                par      <= ^hold;
`endif
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_uart_tx.sv
module tb_adc_sample_uart_tx;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] data = '0;
    logic        tx, busy, ovf;
    logic [15:0] drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    logic sb_off   = 1'b0;
    logic mon_busy = 1'b0;

    adc_sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_data_valid(valid), .I_data(data),
        .O_uart_tx(tx), .O_busy(busy), .O_overflow(ovf), .O_drop_cnt(drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: the sample is split into a marked high byte and an unmarked low byte.
    task automatic expect_sample(input logic [11:0] s);
        exp_q.push_back(8'h80 + 8'(s / 64));
        exp_q.push_back(8'(s % 64));
    endtask

    task automatic send(input logic [11:0] s);
        valid = 1'b1;
        data  = s;
        expect_sample(s);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || mon_busy || exp_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(!(busy || mon_busy || exp_q.size() != 0)), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: decodes each UART frame from the line and checks it against the expected byte queue.
    initial begin : monitor
        logic [10:0] bits;
        logic        stable, aborted, frame_ok;
        logic [7:0]  byte_v;
        int          t_start;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                mon_busy = 1'b1;
                t_start  = cyc;
                stable   = 1'b1;
                aborted  = 1'b0;
                bits     = '0;
                for (int b = 0; b < FB && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        else if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                mon_busy = 1'b0;
                if (!aborted && !sb_off) begin
                    starts.push_back(t_start);
                    byte_v   = bits[8:1];
                    frame_ok = stable && (bits[0] == 1'b0) && (bits[FB-1] == 1'b1);
                    if (FB == 11) frame_ok = frame_ok && (bits[9] == ^byte_v);
                    check("frame_format", 32'(frame_ok), 32'd1);
                    if (exp_q.size() == 0) check("unexpected_byte", 32'(byte_v), 32'hFFFF_FFFF);
                    else check("byte", 32'(byte_v), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [11:0] s;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single sample: latency and busy duration.
        send(12'hABC);
        check("no_fallthrough_tx", 32'(tx), 32'd1);
        check("busy_after_write", 32'(busy), 32'd1);
        @(negedge clk);
        check("start_after_pop", 32'(tx), 32'd0);
        repeat (2 * FB * CPB - 1) @(negedge clk);
        check("busy_hold", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("single_ovf", 32'(ovf), 32'd0);
        wait_idle(200);

        // Two back-to-back samples: byte order and one idle cycle between samples.
        starts.delete();
        valid = 1'b1; data = 12'h000; expect_sample(12'h000);
        @(negedge clk);
        data = 12'hFFF; expect_sample(12'hFFF);
        @(negedge clk);
        valid = 1'b0;
        wait_idle(600);
        check("pair_frames", 32'(starts.size()), 32'd4);
        if (starts.size() == 4) begin
            check("pair_hl_gap", 32'(starts[1] - starts[0]), 32'(FB * CPB));
            check("pair_sample_gap", 32'(starts[2] - starts[1]), 32'(FB * CPB + 1));
            check("pair_hl_gap2", 32'(starts[3] - starts[2]), 32'(FB * CPB));
        end

        // Random spaced samples, slow enough never to fill the FIFO.
        for (int k = 0; k < 30; k++) begin
            s = 12'($urandom);
            send(s);
            repeat ($urandom_range(160, 40)) @(negedge clk);
        end
        wait_idle(4000);
        check("rand_drop", 32'(drop), 32'd0);
        check("rand_ovf", 32'(ovf), 32'd0);

        // Burst: one sample drains straight into the FSM, DEPTH more fill the FIFO, the rest drop.
        for (int i = 0; i < 20; i++) begin
            s = 12'($urandom);
            valid = 1'b1;
            data  = s;
            if (i < DEPTH + 1) expect_sample(s);
            @(negedge clk);
            check("burst_ovf", 32'(ovf), 32'(i >= DEPTH + 1));
        end
        valid = 1'b0;
        check("burst_drops", 32'(drop), 32'(20 - (DEPTH + 1)));
        wait_idle(3000);
        check("burst_ovf_sticky", 32'(ovf), 32'd1);
        check("burst_drops_end", 32'(drop), 32'(20 - (DEPTH + 1)));

        // Reset during data bit 0 of byte H (0xAA has a 0 there).
        send(12'hABC);
        repeat (CPB + 2) @(negedge clk);
        check("pre_reset_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_drop", 32'(drop), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        send(12'h123);
        wait_idle(300);

        // Saturation of the drop counter with the FIFO held full.
        sb_off = 1'b1;
        valid  = 1'b1;
        data   = 12'h555;
        repeat (70000) @(negedge clk);
        check("sat_drop", 32'(drop), 32'hFFFF);
        repeat (2000) @(negedge clk);
        check("sat_drop_hold", 32'(drop), 32'hFFFF);
        check("sat_ovf", 32'(ovf), 32'd1);
        valid = 1'b0;
        do_reset();
        sb_off = 1'b0;
        check("final_rst_drop", 32'(drop), 32'd0);
        check("final_rst_tx", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
